// File: rtl/fakeapr_pkg.sv
// rtl/fakeapr_pkg.sv - shared encodings and reset-pattern helper for the fake APR panel
package fakeapr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_SWITCH = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest register the pattern helper can fill; multiple of 3 so digits align
  localparam int PAT_MAX_WIDTH = 255;

  // Every octal digit of channel ch holds (ch+1) mod 8; bits above width stay 0
  function automatic logic [PAT_MAX_WIDTH-1:0] reset_pattern(input int ch, input int width);
    logic [PAT_MAX_WIDTH-1:0] r;
    logic [2:0]               digit;
    r     = '0;
    digit = 3'((ch + 1) % 8);
    for (int d = 0; d < PAT_MAX_WIDTH / 3; d++) begin
      if (d < width / 3) r[3*d +: 3] = digit;
    end
    return r;
  endfunction

endpackage

// File: rtl/fakeapr_pattern_if.sv
// rtl/fakeapr_pattern_if.sv - panel keys, switches and lamp bus (FAKEAPR_LAMP_TEST_EN adds sw_lamp_test)
interface fakeapr_pattern_if #(
  parameter int WIDTH = 36,
  parameter int NREG  = 4
);
  logic                    key_start;
  logic                    key_inst_stop;
  logic                    key_inst_cont;
  logic                    key_dep;
  logic                    sw_addr_stop;
  logic [1:0]              mode;
  logic [2:0]              sel;
  logic [WIDTH-1:0]        datasw;
  logic [17:0]             mas;
  logic [NREG*WIDTH-1:0]   lights;
  logic [17:0]             pc;
  logic                    run;
  logic                    mc_stop;
`ifdef FAKEAPR_LAMP_TEST_EN
  logic                    sw_lamp_test;

  modport master (
    output key_start, key_inst_stop, key_inst_cont, key_dep, sw_addr_stop,
           mode, sel, datasw, mas, sw_lamp_test,
    input  lights, pc, run, mc_stop
  );

  modport slave (
    input  key_start, key_inst_stop, key_inst_cont, key_dep, sw_addr_stop,
           mode, sel, datasw, mas, sw_lamp_test,
    output lights, pc, run, mc_stop
  );
`else
  modport master (
    output key_start, key_inst_stop, key_inst_cont, key_dep, sw_addr_stop,
           mode, sel, datasw, mas,
    input  lights, pc, run, mc_stop
  );

  modport slave (
    input  key_start, key_inst_stop, key_inst_cont, key_dep, sw_addr_stop,
           mode, sel, datasw, mas,
    output lights, pc, run, mc_stop
  );
`endif
endinterface

// File: rtl/fakeapr_keyedge.sv
// rtl/fakeapr_keyedge.sv - registered rising-edge detector for one panel key
module fakeapr_keyedge (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic edge_o
);
  logic key_q;
  logic edge_q;

  // Remember the last sampled level and flag the first cycle the key is seen high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      key_q  <= key_i;
      edge_q <= key_i & ~key_q;
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/fakeapr_pattern.sv
// rtl/fakeapr_pattern.sv - panel-driven lamp pattern generator (optional FAKEAPR_LAMP_TEST_EN)
module fakeapr_pattern
  import fakeapr_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int NREG  = 4,
  parameter int DIV   = 1024
) (
  input logic              clk,
  input logic              reset,
  fakeapr_pattern_if.slave bus
);
  localparam int              DIVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  typedef logic [WIDTH-1:0] word_t;

  logic            start_e, stop_e, cont_e, dep_e;
  state_e          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [17:0]     pc_q, pc_d, pc_inc;
  word_t           chan_q [NREG];
  word_t           chan_d [NREG];
  logic            mc_stop_q, mc_stop_d;
  logic            run_w, div_wrap, step, dep_ok, addr_hit;
  logic [NREG*WIDTH-1:0] lights_w;

  fakeapr_keyedge u_start (.clk(clk), .reset(reset), .key_i(bus.key_start),     .edge_o(start_e));
  fakeapr_keyedge u_stop  (.clk(clk), .reset(reset), .key_i(bus.key_inst_stop), .edge_o(stop_e));
  fakeapr_keyedge u_cont  (.clk(clk), .reset(reset), .key_i(bus.key_inst_cont), .edge_o(cont_e));
  fakeapr_keyedge u_dep   (.clk(clk), .reset(reset), .key_i(bus.key_dep),       .edge_o(dep_e));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: stop beats start; an address stop lands in the same cycle as its step
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_e && !stop_e) state_d = ST_RUN;
      ST_RUN:  if (stop_e || (step && addr_hit)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: step source depends on state, deposits only while idle
  always_comb begin
    run_w     = (state_q == ST_RUN);
    div_wrap  = (div_q == DIV_LAST);
    step      = run_w ? (div_wrap && !stop_e) : cont_e;
    dep_ok    = !run_w && dep_e && (int'(bus.sel) < NREG);
    pc_inc    = pc_q + 18'd1;
    addr_hit  = bus.sw_addr_stop && (pc_inc == bus.mas);
    mc_stop_d = run_w && (state_d == ST_IDLE);
  end

  // Datapath next values: divider, step counter and every channel
  always_comb begin
    pc_d = step ? pc_inc : pc_q;
    if (!run_w || div_wrap) div_d = '0;
    else                    div_d = div_q + DIVW'(1);
    for (int i = 0; i < NREG; i++) begin
      chan_d[i] = chan_q[i];
      if (step) begin
        case (mode_e'(bus.mode))
          MODE_HOLD:   chan_d[i] = chan_q[i];
          MODE_COUNT:  chan_d[i] = chan_q[i] + WIDTH'(1);
          MODE_WALK:   chan_d[i] = {chan_q[i][0], chan_q[i][WIDTH-1:1]};
          MODE_SWITCH: chan_d[i] = bus.datasw;
        endcase
      end
      if (dep_ok && (int'(bus.sel) == i)) chan_d[i] = bus.datasw;
    end
  end

  // Datapath registers; reset loads the per-channel octal digit pattern
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      pc_q      <= '0;
      mc_stop_q <= 1'b0;
      for (int i = 0; i < NREG; i++) chan_q[i] <= WIDTH'(reset_pattern(i, WIDTH));
    end else begin
      div_q     <= div_d;
      pc_q      <= pc_d;
      mc_stop_q <= mc_stop_d;
      for (int i = 0; i < NREG; i++) chan_q[i] <= chan_d[i];
    end
  end

  // Pack channels onto the lamp bus, channel i at [i*WIDTH +: WIDTH]
  always_comb begin
    lights_w = '0;
    for (int i = 0; i < NREG; i++) lights_w[i*WIDTH +: WIDTH] = chan_q[i];
  end

`ifdef FAKEAPR_LAMP_TEST_EN
  assign bus.lights = bus.sw_lamp_test ? '1 : lights_w;
  assign bus.pc     = bus.sw_lamp_test ? '1 : pc_q;
`else
  assign bus.lights = lights_w;
  assign bus.pc     = pc_q;
`endif
  assign bus.run     = run_w;
  assign bus.mc_stop = mc_stop_q;
endmodule

// File: tb/tb_fakeapr_pattern.sv
// tb/tb_fakeapr_pattern.sv - self-checking bench for fakeapr_pattern
module tb_fakeapr_pattern;
  localparam int WIDTH = 36;
  localparam int NREG  = 4;
  localparam int DIV   = 4;
  localparam int LW    = NREG * WIDTH;
  localparam logic [LW-1:0] RST_LIGHTS = {36'o444444444444, 36'o333333333333,
                                          36'o222222222222, 36'o111111111111};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mc_cnt = 0;
  bit   run_seen = 1'b0;

  fakeapr_pattern_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  fakeapr_pattern #(.WIDTH(WIDTH), .NREG(NREG), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: key histories, run age, step counter and channel values
  bit               m_run, m_mc, was_run, do_step, do_dep;
  int               m_age;
  logic [17:0]      m_pc;
  logic [WIDTH-1:0] m_ch [NREG];
  logic [3:0]       s1, s2, ev;
  logic [2*WIDTH-1:0] tmp;

  function automatic logic [LW-1:0] model_lights();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i*WIDTH +: WIDTH] = m_ch[i];
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_mc = 0; m_age = 0; m_pc = '0; s1 = '0; s2 = '0;
      for (int i = 0; i < NREG; i++) m_ch[i] = WIDTH'((i + 1) % 8) * 36'o111111111111;
    end else begin
      ev = s1 & ~s2;
      s2 = s1;
      s1 = {bus.key_dep, bus.key_inst_cont, bus.key_inst_stop, bus.key_start};
      m_mc = 0; do_step = 0; do_dep = 0; was_run = m_run;
      if (m_run) begin
        if (ev[1]) begin m_run = 0; m_mc = 1; end
        else begin m_age++; do_step = (m_age % DIV == 0); end
      end else begin
        do_step = ev[2];
        do_dep  = ev[3] && (int'(bus.sel) < NREG);
        if (ev[0] && !ev[1]) begin m_run = 1; m_age = 0; end
      end
      if (do_step) begin
        for (int i = 0; i < NREG; i++) begin
          case (bus.mode)
            2'd1: m_ch[i] = m_ch[i] + WIDTH'(1);
            2'd2: begin tmp = {m_ch[i], m_ch[i]} >> 1; m_ch[i] = tmp[WIDTH-1:0]; end
            2'd3: m_ch[i] = bus.datasw;
            default: ;
          endcase
        end
        m_pc = m_pc + 18'd1;
        if (was_run && bus.sw_addr_stop && m_pc == bus.mas) begin m_run = 0; m_mc = 1; end
      end
      if (do_dep) m_ch[int'(bus.sel)] = bus.datasw;
    end
  end

  // Cycle compare of every output against the model
  always @(posedge clk) begin
    #1;
    check("cyc_lights",  bus.lights,      model_lights());
    check("cyc_pc",      LW'(bus.pc),      LW'(m_pc));
    check("cyc_run",     LW'(bus.run),     LW'(m_run));
    check("cyc_mc_stop", LW'(bus.mc_stop), LW'(m_mc));
    if (bus.mc_stop) mc_cnt++;
    if (bus.run) run_seen = 1'b1;
  end

  task automatic set_keys(input logic [3:0] m);
    bus.key_start     = m[0];
    bus.key_inst_stop = m[1];
    bus.key_inst_cont = m[2];
    bus.key_dep       = m[3];
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk); set_keys(m);
    repeat (2) @(negedge clk); set_keys(4'b0000);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc_before;
    bit ok;
    logic [LW-1:0] snap;
    set_keys(4'b0000);
    bus.sw_addr_stop = 0; bus.mode = 2'd0; bus.sel = 3'd0; bus.datasw = '0; bus.mas = '0;
`ifdef FAKEAPR_LAMP_TEST_EN
    bus.sw_lamp_test = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_lights", bus.lights, RST_LIGHTS);
    check("rst_pc", LW'(bus.pc), '0);
    check("rst_run", LW'(bus.run), '0);
    check("rst_mc_stop", LW'(bus.mc_stop), '0);
    reset = 1;
    repeat (2) @(negedge clk);
    check("rel_lights", bus.lights, RST_LIGHTS);

    // COUNT run, stop raised ten cycles after start
    bus.mode = 2'd1;
    @(negedge clk); bus.key_start = 1;
    repeat (2) @(negedge clk); bus.key_start = 0;
    repeat (8) @(negedge clk); bus.key_inst_stop = 1;
    repeat (2) @(negedge clk); bus.key_inst_stop = 0;
    repeat (3) @(negedge clk);
    check("count_ch0", LW'(bus.lights[35:0]), LW'(36'o111111111113));
    check("count_pc", LW'(bus.pc), LW'(18'd2));
    check("count_mc_pulses", LW'(mc_cnt), LW'(1));
    check("count_run", LW'(bus.run), '0);

    // WALK single step after a deposit into channel 1
    bus.mode = 2'd2; bus.sel = 3'd1; bus.datasw = 36'o000000000001;
    pulse(4'b1000);
    pulse(4'b0100);
    check("walk_ch1", LW'(bus.lights[71:36]), LW'(36'o400000000000));
    check("walk_run", LW'(bus.run), '0);

    // SWITCH single step loads all channels
    bus.mode = 2'd3; bus.datasw = 36'o123456701234;
    pulse(4'b0100);
    check("switch_ch3", LW'(bus.lights[143:108]), LW'(36'o123456701234));

    // Address stop on the fifth step
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    bus.mode = 2'd0; bus.sw_addr_stop = 1; bus.mas = 18'd5;
    mc_before = mc_cnt;
    pulse(4'b0001);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!bus.run) begin ok = 1; break; end
    end
    check("addr_stop_wait", LW'(ok), LW'(1));
    check("addr_stop_pc", LW'(bus.pc), LW'(18'd5));
    check("addr_stop_mc", LW'(mc_cnt - mc_before), LW'(1));
    check("addr_stop_hold", bus.lights, RST_LIGHTS);
    bus.sw_addr_stop = 0;

    // Simultaneous start/stop, then an out-of-range deposit
    run_seen = 0;
    pulse(4'b0011);
    check("startstop_run", LW'(run_seen), '0);
    snap = model_lights();
    bus.sel = 3'd6; bus.datasw = 36'o777000777000;
    pulse(4'b1000);
    check("dep_oob_lights", bus.lights, snap);

    // Asynchronous reset mid-RUN
    bus.mode = 2'd1;
    pulse(4'b0001);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.pc == 18'd7) begin ok = 1; break; end
    end
    check("midrun_wait", LW'(ok), LW'(1));
    mc_before = mc_cnt;
    #2 reset = 0;
    #1;
    check("async_lights", bus.lights, RST_LIGHTS);
    check("async_pc", LW'(bus.pc), '0);
    check("async_run", LW'(bus.run), '0);
    check("async_mc_stop", LW'(bus.mc_stop), '0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("async_no_mc", LW'(mc_cnt - mc_before), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fakeapr_pattern.md
FAKEAPR_PATTERN -- requirements
Module: fakeapr_pattern

Interface
REQ-001 The block SHALL have parameter WIDTH, default 36: register width in bits; must be a multiple of 3.
REQ-002 The block SHALL have parameter NREG, default 4: number of display register channels, 1..8.
REQ-003 The block SHALL have parameter DIV, default 1024: clock cycles per RUN step, >= 1.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 key_start  input  1  panel key level; rising edge starts RUN.
REQ-007 key_inst_stop  input  1  panel key level; rising edge stops.
REQ-008 key_inst_cont  input  1  panel key level; rising edge performs one step while stopped.
REQ-009 key_dep  input  1  panel key level; rising edge deposits datasw into the selected channel.
REQ-010 sw_addr_stop  input  1  enables the address-stop compare.
REQ-011 mode  input  2  step mode: 0 HOLD, 1 COUNT, 2 WALK, 3 SWITCH.
REQ-012 sel  input  3  channel select for deposit.
REQ-013 datasw  input  WIDTH  data switches, bit 0 is the MSB.
REQ-014 mas  input  18  address-stop compare value.
REQ-015 lights  output  NREG*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-016 pc  output  18  step counter.
REQ-017 run  output  1  high in RUN.
REQ-018 mc_stop  output  1  one-cycle pulse on any RUN-to-IDLE transition.

Function
REQ-019 Keys SHALL be edge-detected with one registered stage; an edge acts at the clock edge after the key is first sampled high.
REQ-020 The FSM SHALL have states IDLE and RUN.
REQ-021 IDLE->RUN on a start edge; the divider clears to 0.
REQ-022 RUN->IDLE on a stop edge or an address stop.
REQ-023 In RUN, the divider SHALL count 0..DIV-1, with one step when it wraps; first step DIV cycles after entering RUN.
REQ-024 In IDLE, an inst_cont edge SHALL perform exactly one step.
REQ-025 inst_cont SHALL be ignored in RUN.
REQ-026 A step SHALL update all channels per mode sampled that cycle.
REQ-027 HOLD: channels unchanged.
REQ-028 COUNT: channel += 1 mod 2^WIDTH.
REQ-029 WALK: rotate right by one toward higher bit index; bit WIDTH-1 -> bit 0.
REQ-030 SWITCH: channel <= datasw.
REQ-031 Each step SHALL increment pc mod 2^18.
REQ-032 If sw_addr_stop and the new pc equals mas, the FSM SHALL enter IDLE in the same cycle as that step.
REQ-033 A dep edge in IDLE SHALL load datasw into channel sel.
REQ-034 A dep edge in RUN, or with sel >= NREG, SHALL be ignored.
REQ-035 When start and stop edges occur in the same cycle, stop SHALL win (stays or goes IDLE).
REQ-036 A dep edge coinciding with an inst_cont step: deposit wins for channel sel; the other channels step.

Reset
REQ-037 While reset is low, the block SHALL hold: state IDLE, run 0, mc_stop 0, pc 0, divider 0, edge registers 0.
REQ-038 While reset is low, each channel i SHALL hold every octal digit = (i+1) mod 8; channel 0 = 111...1 octal.
REQ-039 Reset asserted mid-RUN SHALL abort immediately with no mc_stop pulse.

Configuration
REQ-040 Macro FAKEAPR_LAMP_TEST_EN: when defined, adds input sw_lamp_test (1 bit); while it is high, lights and pc are forced all-ones with internal state unaffected.
REQ-041 Without FAKEAPR_LAMP_TEST_EN, the port and logic SHALL be absent.

Structure
REQ-042 Package fakeapr_pkg SHALL hold the mode encoding constants, FSM state encoding, and the reset-pattern function of (channel index, WIDTH).
REQ-043 One sub-module, fakeapr_keyedge (registered rising-edge detector, reset to 0), SHALL be instantiated per key.

Verification
REQ-044 Reset release, WIDTH=36, NREG=4 -> lights ch0..3 = 36'o111111111111, 36'o222222222222, 36'o333333333333, 36'o444444444444; pc 0; run 0.
REQ-045 mode=1, DIV=4, start edge, then stop after 10 cycles -> exactly 2 steps, ch0 = 36'o111111111113, pc 2, one mc_stop pulse.
REQ-046 IDLE, mode=2, ch1 deposited 36'o000000000001, one inst_cont -> ch1 = 36'o400000000000, run stays 0.
REQ-047 sw_addr_stop=1, mas=5, mode=0, start -> run falls on the 5th step, pc 5, mc_stop pulses once.
REQ-048 Start and stop keys raised in the same cycle from IDLE -> run stays 0; dep with sel=6 and NREG=4 -> no channel changes.
REQ-049 Reset pulled low mid-RUN with pc=7 -> all values return to REQ-044 values asynchronously, and no mc_stop pulse occurs.
